axi4_mem_responder: RTL and testbench

- AXI4 slave (responder) that answers the AXI4 master port of noc_axi4_bridge from an on-chip byte-enabled memory.
- Stands in for the DDR4 controller in simulation and in DDR-less FPGA builds.
- Serves one transaction at a time: one write burst or one read burst.
- Supports FIXED and INCR bursts and full-width beats only; other bursts and sizes get error responses.

---
 rtl/axi4_resp_pkg.sv | 24 ++
 rtl/axi4_mem_responder_ram.sv | 34 +++
 rtl/axi4_mem_responder.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi4_mem_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_resp_pkg.sv
// Shared AXI4 response/burst codes and responder FSM encoding.
package axi4_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // state    | meaning
  // ST_IDLE  | waiting for AW or AR, round-robin between them
  // ST_WDATA | accepting len+1 write beats
  // ST_WRESP | holding B until bready
  // ST_RDATA | streaming len+1 read beats
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WDATA = 2'b01,
    ST_WRESP = 2'b10,
    ST_RDATA = 2'b11
  } state_t;

endpackage

// File: rtl/axi4_mem_responder_ram.sv
// Single-port synchronous RAM, per-byte write enable, registered read data.
module axi4_mem_responder_ram #(
  parameter int DATA_WIDTH = 512,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                          clk,
  input  logic                          i_en,
  input  logic [DATA_WIDTH/8-1:0]       i_we,
  input  logic [$clog2(MEM_WORDS)-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  output logic [DATA_WIDTH-1:0]         o_rdata
);

  localparam int STRB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read data only updates on a read access, so it holds across stalls.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (|i_we) begin
        for (int b = 0; b < STRB; b++) begin
          if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 slave answering one burst at a time from on-chip byte-enabled memory.
module axi4_mem_responder
  import axi4_resp_pkg::*;
#(
  parameter int ID_WIDTH   = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int MEM_WORDS  = 1024,
  parameter int USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [USER_WIDTH-1:0]   s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_wid,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [USER_WIDTH-1:0]   s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [USER_WIDTH-1:0]   s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [USER_WIDTH-1:0]   s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [USER_WIDTH-1:0]   s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam int BSZ  = $clog2(STRB);
  localparam int IW   = $clog2(MEM_WORDS);
  localparam logic [2:0] SIZE_FULL = 3'(BSZ);

  state_t                r_state, w_state_nxt;
  logic                  r_prio_wr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [7:0]            r_len, r_cnt;
  logic [IW-1:0]         r_idx;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic                  r_bvalid, r_rvalid, r_rlast;
  logic [1:0]            r_bresp, r_rresp;
  logic [ID_WIDTH-1:0]   r_bid, r_rid;

  logic                  w_awready, w_arready, w_aw_hs, w_ar_hs;
  logic                  w_aw_err, w_ar_err, w_wlast_bad, w_w_final;
  logic [IW-1:0]         w_aw_idx, w_ar_idx;
  logic                  w_ram_en;
  logic [STRB-1:0]       w_ram_we;
  logic [IW-1:0]         w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx, input logic [1:0] burst);
    return (burst == BURST_INCR) ? idx + 1'b1 : idx;
  endfunction

  // Exactly one side may be ready in IDLE; contention goes to the side not served last.
  assign w_awready = rst_n && (r_state == ST_IDLE) && s_axi_awvalid &&
                     (!s_axi_arvalid || r_prio_wr);
  assign w_arready = rst_n && (r_state == ST_IDLE) && s_axi_arvalid &&
                     (!s_axi_awvalid || !r_prio_wr);
  assign w_aw_hs   = w_awready && s_axi_awvalid;
  assign w_ar_hs   = w_arready && s_axi_arvalid;

  assign w_aw_idx  = s_axi_awaddr[BSZ +: IW];
  assign w_ar_idx  = s_axi_araddr[BSZ +: IW];
  assign w_aw_err  = (s_axi_awsize != SIZE_FULL) || s_axi_awburst[1];
  assign w_ar_err  = (s_axi_arsize != SIZE_FULL) || s_axi_arburst[1];

  assign w_w_final   = (r_cnt == r_len);
  assign w_wlast_bad = (s_axi_wlast != w_w_final);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_prio_wr <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_hs)      r_prio_wr <= 1'b0;
      else if (w_ar_hs) r_prio_wr <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ram_en    = 1'b0;
    w_ram_we    = '0;
    w_ram_addr  = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_aw_hs) begin
          w_state_nxt = ST_WDATA;
        end else if (w_ar_hs) begin
          w_state_nxt = ST_RDATA;
          w_ram_en    = 1'b1;
          w_ram_addr  = w_ar_idx;
        end
      end
      ST_WDATA: begin
        if (s_axi_wvalid) begin
          w_ram_en = rst_n;
          w_ram_we = r_err ? '0 : s_axi_wstrb;
          if (w_w_final) w_state_nxt = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (s_axi_bready) w_state_nxt = ST_IDLE;
      end
      ST_RDATA: begin
        if (s_axi_rready) begin
          if (r_rlast) w_state_nxt = ST_IDLE;
          else         w_ram_en    = rst_n;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id     <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_burst  <= BURST_FIXED;
      r_err    <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_bid    <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rid    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_id    <= s_axi_awid;
            r_len   <= s_axi_awlen;
            r_cnt   <= '0;
            r_idx   <= w_aw_idx;
            r_burst <= s_axi_awburst;
            r_err   <= w_aw_err;
          end else if (w_ar_hs) begin
            // The first beat is read now, so r_idx already points at the second.
            r_id     <= s_axi_arid;
            r_len    <= s_axi_arlen;
            r_cnt    <= '0;
            r_idx    <= next_idx(w_ar_idx, s_axi_arburst);
            r_burst  <= s_axi_arburst;
            r_err    <= w_ar_err;
            r_rvalid <= 1'b1;
            r_rlast  <= (s_axi_arlen == 8'd0);
            r_rid    <= s_axi_arid;
            r_rresp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_WDATA: begin
          if (s_axi_wvalid) begin
            r_cnt <= r_cnt + 8'd1;
            r_idx <= next_idx(r_idx, r_burst);
            if (w_wlast_bad) r_err <= 1'b1;
            if (w_w_final) begin
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= (r_err || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        ST_WRESP: begin
          if (s_axi_bready) r_bvalid <= 1'b0;
        end
        ST_RDATA: begin
          if (s_axi_rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_rlast <= ((r_cnt + 8'd1) == r_len);
              r_idx   <= next_idx(r_idx, r_burst);
            end
          end
        end
        default: ;
      endcase
    end
  end

  axi4_mem_responder_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (s_axi_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign s_axi_awready = w_awready;
  assign s_axi_arready = w_arready;
  assign s_axi_wready  = rst_n && (r_state == ST_WDATA);
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_bid;
  assign s_axi_buser   = '0;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = (r_rvalid && !r_err) ? w_ram_rdata : '0;
  assign s_axi_ruser   = '0;

  logic w_unused;
  assign w_unused = &{1'b0, s_axi_awaddr, s_axi_araddr, s_axi_awlock, s_axi_awcache,
                      s_axi_awprot, s_axi_awqos, s_axi_awregion, s_axi_awuser,
                      s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                      s_axi_arregion, s_axi_aruser, s_axi_wid, s_axi_wuser};

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Scoreboard bench for axi4_mem_responder: bursts, strobes, arbitration, errors, stalls, reset.
module tb_axi4_mem_responder;
  import axi4_resp_pkg::*;

  localparam int IDW = 16;
  localparam int AW  = 64;
  localparam int DW  = 512;
  localparam int SB  = DW / 8;
  localparam int MW  = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [IDW-1:0] awid = '0, arid = '0, wid = '0;
  logic [AW-1:0]  awaddr = '0, araddr = '0;
  logic [7:0]     awlen = '0, arlen = '0;
  logic [2:0]     awsize = '0, arsize = '0;
  logic [1:0]     awburst = '0, arburst = '0;
  logic           awvalid = 1'b0, arvalid = 1'b0;
  logic [DW-1:0]  wdata = '0;
  logic [SB-1:0]  wstrb = '0;
  logic           wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;

  logic           awready, arready, wready, bvalid, rvalid, rlast;
  logic [IDW-1:0] bid, rid;
  logic [1:0]     bresp, rresp;
  logic [DW-1:0]  rdata;
  logic           buser, ruser;

  axi4_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awqos(4'd0), .s_axi_awregion(4'd0), .s_axi_awuser(1'b0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wuser(1'b0), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arqos(4'd0), .s_axi_arregion(4'd0), .s_axi_aruser(1'b0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_ruser(ruser), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0]  d;
    logic [1:0]     resp;
    logic           last;
    logic [IDW-1:0] id;
  } rexp_t;

  rexp_t         rq[$];
  logic [DW-1:0] model [MW];

  function automatic logic [AW-1:0] addr_of(input int idx);
    return AW'(idx) << 6;
  endfunction

  function automatic logic exp_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd6) || burst[1];
  endfunction

  task automatic do_aw(input logic [IDW-1:0] id, input int idx, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge clk);
    awid = id; awaddr = addr_of(idx); awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    #1;
    while (awready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
    tests++;
    if (n >= 100) begin fails++; $display("FAIL aw_handshake: awready=%b required 1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [7:0] len, input logic [DW-1:0] base, input logic [SB-1:0] strb);
    for (int i = 0; i <= int'(len); i++) begin
      int n = 0;
      wdata = base + DW'(i); wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
      #1;
      while (wready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      if (n >= 100) begin tests++; fails++; $display("FAIL w_handshake: wready=%b required 1", wready); end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    tests++;
    if (bvalid !== 1'b1) begin fails++; $display("FAIL b_latency: bvalid=%b required 1", bvalid); end
  endtask

  task automatic do_b(input logic [IDW-1:0] id, input logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    #1;
    while (bvalid !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
    tests++;
    if (bvalid !== 1'b1 || bid !== id || bresp !== resp) begin
      fails++;
      $display("FAIL b_resp: bvalid=%b bid=%h bresp=%b required 1 %h %b", bvalid, bid, bresp, id, resp);
    end
    @(negedge clk);
    bready = 1'b0;
    #1;
    tests++;
    if (bvalid !== 1'b0) begin fails++; $display("FAIL b_clear: bvalid=%b required 0", bvalid); end
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input int idx, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [DW-1:0] base, input logic [SB-1:0] strb);
    logic err;
    int   cur;
    err = exp_err(size, burst);
    do_aw(id, idx, len, size, burst);
    do_w(len, base, strb);
    if (!err) begin
      cur = idx;
      for (int i = 0; i <= int'(len); i++) begin
        logic [DW-1:0] d;
        d = base + DW'(i);
        for (int b = 0; b < SB; b++) if (strb[b]) model[cur][b*8 +: 8] = d[b*8 +: 8];
        if (burst == BURST_INCR) cur = (cur + 1) % MW;
      end
    end
    do_b(id, err ? RESP_SLVERR : RESP_OKAY);
  endtask

  // mode 0: rready held high, no bubbles allowed; mode 1: rready pattern 1,0,0 with hold checks.
  task automatic collect_r(input int nbeats, input int mode);
    int            got = 0;
    int            cyc = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] hd;
    logic [1:0]    hr;
    logic          hl;
    logic [IDW-1:0] hi;
    while (got < nbeats && cyc < 1000) begin
      rready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      if (stalled) begin
        tests++;
        if (rvalid !== 1'b1 || rdata !== hd || rresp !== hr || rlast !== hl || rid !== hi) begin
          fails++;
          $display("FAIL r_hold: beat %0d rvalid=%b rlast=%b rresp=%b rid=%h required 1 %b %b %h",
                   got, rvalid, rlast, rresp, rid, hl, hr, hi);
        end
      end
      if (rvalid === 1'b1) begin
        if (rready) begin
          rexp_t e;
          tests++;
          if (rq.size() == 0) begin
            fails++; $display("FAIL r_extra: unexpected beat rdata=%h", rdata);
          end else begin
            e = rq.pop_front();
            if (rdata !== e.d || rresp !== e.resp || rlast !== e.last || rid !== e.id) begin
              fails++;
              $display("FAIL r_beat: beat %0d rdata=%h rresp=%b rlast=%b rid=%h required %h %b %b %h",
                       got, rdata, rresp, rlast, rid, e.d, e.resp, e.last, e.id);
            end
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; hd = rdata; hr = rresp; hl = rlast; hi = rid;
        end
      end else if (mode == 0) begin
        tests++; fails++;
        $display("FAIL r_bubble: beat %0d rvalid=%b required 1", got, rvalid);
      end
      cyc++;
      @(negedge clk);
    end
    rready = 1'b0;
    tests++;
    if (got != nbeats) begin fails++; $display("FAIL r_count: beats=%0d required %0d", got, nbeats); end
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input int idx, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode);
    logic err;
    int   cur;
    int   n = 0;
    err = exp_err(size, burst);
    cur = idx;
    for (int i = 0; i <= int'(len); i++) begin
      rexp_t e;
      e.d = err ? '0 : model[cur];
      e.resp = err ? RESP_SLVERR : RESP_OKAY;
      e.last = (i == int'(len));
      e.id = id;
      rq.push_back(e);
      if (burst == BURST_INCR) cur = (cur + 1) % MW;
    end
    @(negedge clk);
    arid = id; araddr = addr_of(idx); arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    #1;
    while (arready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
    tests++;
    if (n >= 100) begin fails++; $display("FAIL ar_handshake: arready=%b required 1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
    collect_r(int'(len) + 1, mode);
  endtask

  task automatic check_idle_outputs(input string nm);
    tests++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0 || bresp !== 2'b0 ||
        rresp !== 2'b0 || bid !== '0 || rid !== '0 || rdata !== '0) begin
      fails++;
      $display("FAIL %s: awr=%b arr=%b wr=%b bv=%b rv=%b rl=%b bresp=%b rresp=%b bid=%h rid=%h required all 0",
               nm, awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("reset_state");
  endtask

  task automatic test_basic();
    do_write(16'h0005, 1, 8'd3, 3'd6, BURST_INCR, DW'(32'hA), '1);
    do_read(16'h0007, 1, 8'd3, 3'd6, BURST_INCR, 0);
  endtask

  task automatic test_partial_strobe();
    logic [DW-1:0] req;
    do_write(16'h0002, 5, 8'd0, 3'd6, BURST_INCR, '1, '1);
    do_write(16'h0002, 5, 8'd0, 3'd6, BURST_INCR, '0, SB'(1));
    req = '1;
    req[7:0] = 8'h00;
    tests++;
    if (model[5] !== req) begin fails++; $display("FAIL strobe_model: %h required %h", model[5], req); end
    do_read(16'h0003, 5, 8'd0, 3'd6, BURST_INCR, 0);
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    rst_n = 1'b0;
    awid = 16'h1; awaddr = addr_of(10); awlen = 0; awsize = 3'd6; awburst = BURST_INCR; awvalid = 1'b1;
    arid = 16'h2; araddr = addr_of(10); arlen = 0; arsize = 3'd6; arburst = BURST_INCR; arvalid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      fails++; $display("FAIL arb_first: awready=%b arready=%b required 1 0", awready, arready);
    end
    @(negedge clk);
    awvalid = 1'b0;
    wdata = DW'(32'h77); wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
    #1;
    tests++;
    if (awready !== 1'b0 || arready !== 1'b0) begin
      fails++; $display("FAIL arb_busy: awready=%b arready=%b required 0 0", awready, arready);
    end
    model[10] = DW'(32'h77);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1;
    tests++;
    if (bvalid !== 1'b1 || bid !== 16'h1 || bresp !== RESP_OKAY) begin
      fails++; $display("FAIL arb_b: bvalid=%b bid=%h bresp=%b required 1 0001 00", bvalid, bid, bresp);
    end
    @(negedge clk);
    bready = 1'b0;
    awid = 16'h3; awaddr = addr_of(11); awvalid = 1'b1;
    #1;
    tests++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      fails++; $display("FAIL arb_second: awready=%b arready=%b required 0 1", awready, arready);
    end
    @(negedge clk);
    rready = 1'b1;
    #1;
    tests++;
    if (rvalid !== 1'b1 || rdata !== model[10] || rlast !== 1'b1 || rid !== 16'h2) begin
      fails++; $display("FAIL arb_r: rvalid=%b rlast=%b rid=%h rdata=%h required 1 1 0002 %h",
                        rvalid, rlast, rid, rdata, model[10]);
    end
    @(negedge clk);
    rready = 1'b0;
    #1;
    tests++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      fails++; $display("FAIL arb_third: awready=%b arready=%b required 1 0", awready, arready);
    end
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    do_w(8'd0, DW'(32'h88), '1);
    model[11] = DW'(32'h88);
    do_b(16'h3, RESP_OKAY);
    do_read(16'h4, 10, 8'd1, 3'd6, BURST_INCR, 0);
  endtask

  task automatic test_errors();
    do_write(16'h0004, 20, 8'd1, 3'd6, BURST_INCR, DW'(32'h500), '1);
    do_write(16'h0004, 20, 8'd1, 3'd3, BURST_INCR, DW'(32'h900), '1);
    do_read(16'h0005, 20, 8'd1, 3'd6, BURST_INCR, 0);
    do_read(16'h0006, 20, 8'd1, 3'd6, BURST_WRAP, 0);
  endtask

  task automatic test_wrap_stall();
    do_write(16'h000C, MW - 4, 8'd7, 3'd6, BURST_INCR, DW'(32'hC00), '1);
    tests++;
    if (model[0] !== DW'(32'hC04)) begin fails++; $display("FAIL wrap_model: %h required c04", model[0]); end
    do_read(16'h000D, MW - 4, 8'd7, 3'd6, BURST_INCR, 1);
    do_read(16'h000E, MW - 1, 8'd3, 3'd6, BURST_FIXED, 0);
  endtask

  task automatic test_reset_mid_burst();
    do_aw(16'h0009, 30, 8'd3, 3'd6, BURST_INCR);
    wdata = DW'(32'h1111); wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    wdata = DW'(32'h2222); rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; wvalid = 1'b0;
    #1;
    check_idle_outputs("reset_mid_burst");
    model[30] = DW'(32'h1111);
    repeat (3) @(negedge clk);
    tests++;
    if (bvalid !== 1'b0) begin fails++; $display("FAIL reset_no_b: bvalid=%b required 0", bvalid); end
    do_write(16'h000A, 31, 8'd0, 3'd6, BURST_INCR, DW'(32'h3333), '1);
    do_read(16'h000B, 30, 8'd1, 3'd6, BURST_INCR, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_strobe();
    test_arbitration();
    test_errors();
    test_wrap_stall();
    test_reset_mid_burst();
    tests++;
    if (rq.size() != 0) begin fails++; $display("FAIL scoreboard_left: %0d required 0", rq.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
